// File: rtl/flit_sink_monitor.sv
// Flit sink that checks an incrementing payload sequence and counts flits and errors.
// Define SINK_BACKPRESSURE_EN to insert one forced stall cycle every STALL_PERIOD accepted flits.

`ifndef SIZE
`define SIZE 8
`endif

module flit_sink_monitor #(
    parameter int ID           = 0,
    parameter int DATA_W       = `SIZE,
    parameter int MAX_FLITS    = 16,
    parameter int STALL_PERIOD = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    output logic              ack,
    output logic [15:0]       flit_count,
    output logic [7:0]        err_count,
    output logic              err,
    output logic              done,
    output logic [DATA_W-1:0] last_data
);

    if (MAX_FLITS < 1 || MAX_FLITS > 65535) begin : g_bad_max_flits
        $error("flit_sink_monitor: MAX_FLITS out of range 1..65535");
    end
    if (STALL_PERIOD < 1 || STALL_PERIOD > 255) begin : g_bad_stall_period
        $error("flit_sink_monitor: STALL_PERIOD out of range 1..255");
    end

    localparam logic [15:0] MAX_C = 16'(MAX_FLITS);

`ifdef SINK_BACKPRESSURE_EN
    localparam logic [7:0] STALL_C = 8'(STALL_PERIOD);
    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_STALL = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [15:0]         flit_count_q, flit_count_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   last_data_q, last_data_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic                transfer;
`ifdef SINK_BACKPRESSURE_EN
    logic [7:0]          stall_cnt_q, stall_cnt_d;
`endif

    assign transfer = req & ack_q;

    always_comb begin
        state_d      = state_q;
        flit_count_d = flit_count_q;
        err_count_d  = err_count_q;
        err_d        = err_q;
        last_data_d  = last_data_q;
        expected_d   = expected_q;
`ifdef SINK_BACKPRESSURE_EN
        stall_cnt_d  = stall_cnt_q;
`endif

        if (transfer) begin
            flit_count_d = flit_count_q + 16'd1;
            last_data_d  = data;
            expected_d   = expected_q + 1'b1;
            if (data != expected_q) begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end

        case (state_q)
            S_READY: begin
                if (transfer) begin
                    // Reaching the flit limit wins over a stall due on the same flit.
                    if (flit_count_q == MAX_C - 16'd1) begin
                        state_d = S_DONE;
                    end
`ifdef SINK_BACKPRESSURE_EN
                    else if (stall_cnt_q == STALL_C - 8'd1) begin
                        state_d     = S_STALL;
                        stall_cnt_d = 8'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
`endif
                end
            end
`ifdef SINK_BACKPRESSURE_EN
            S_STALL: state_d = S_READY;
`endif
            S_DONE:  state_d = S_DONE;
            default: state_d = S_READY;
        endcase

        // ack is registered from the next state so it never follows req/data combinationally.
        ack_d = (state_d == S_READY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_READY;
            ack_q        <= 1'b1;
            flit_count_q <= 16'd0;
            err_count_q  <= 8'd0;
            err_q        <= 1'b0;
            last_data_q  <= '0;
            expected_q   <= '0;
`ifdef SINK_BACKPRESSURE_EN
            stall_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            flit_count_q <= flit_count_d;
            err_count_q  <= err_count_d;
            err_q        <= err_d;
            last_data_q  <= last_data_d;
            expected_q   <= expected_d;
`ifdef SINK_BACKPRESSURE_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && transfer && (data != expected_q)) begin
            $display("flit_sink_monitor %0d: sequence error, expected %0h received %0h",
                     ID, expected_q, data);
        end
    end
`endif

    assign ack        = ack_q;
    assign flit_count = flit_count_q;
    assign err_count  = err_count_q;
    assign err        = err_q;
    assign done       = (state_q == S_DONE);
    assign last_data  = last_data_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed bench for flit_sink_monitor; four instances cover limit, backpressure, wrap and saturation.

module tb_flit_sink_monitor;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // a: MAX_FLITS=2 ; b: MAX_FLITS=8, STALL_PERIOD=3 ; c: DATA_W=2, MAX_FLITS=6 ; d: MAX_FLITS=400
    logic       req_a = 0, req_b = 0, req_c = 0, req_d = 0;
    logic [7:0] data_a = 0, data_b = 0, data_d = 0;
    logic [1:0] data_c = 0;
    logic       ack_a, ack_b, ack_c, ack_d;
    logic [15:0] fc_a, fc_b, fc_c, fc_d;
    logic [7:0] ec_a, ec_b, ec_c, ec_d;
    logic       err_a, err_b, err_c, err_d;
    logic       done_a, done_b, done_c, done_d;
    logic [7:0] ld_a, ld_b, ld_d;
    logic [1:0] ld_c;

    flit_sink_monitor #(.ID(1), .DATA_W(8), .MAX_FLITS(2), .STALL_PERIOD(3)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .data(data_a), .ack(ack_a),
        .flit_count(fc_a), .err_count(ec_a), .err(err_a), .done(done_a), .last_data(ld_a));
    flit_sink_monitor #(.ID(2), .DATA_W(8), .MAX_FLITS(8), .STALL_PERIOD(3)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .data(data_b), .ack(ack_b),
        .flit_count(fc_b), .err_count(ec_b), .err(err_b), .done(done_b), .last_data(ld_b));
    flit_sink_monitor #(.ID(3), .DATA_W(2), .MAX_FLITS(6), .STALL_PERIOD(3)) u_c (
        .clk(clk), .reset(reset), .req(req_c), .data(data_c), .ack(ack_c),
        .flit_count(fc_c), .err_count(ec_c), .err(err_c), .done(done_c), .last_data(ld_c));
    flit_sink_monitor #(.ID(4), .DATA_W(8), .MAX_FLITS(400), .STALL_PERIOD(255)) u_d (
        .clk(clk), .reset(reset), .req(req_d), .data(data_d), .ack(ack_d),
        .flit_count(fc_d), .err_count(ec_d), .err(err_d), .done(done_d), .last_data(ld_d));

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ack_a !== 1'b1 || ack_b !== 1'b1 || ack_c !== 1'b1 || ack_d !== 1'b1) begin
            bad++; $display("FAIL reset_ack got=%b%b%b%b want=1111", ack_a, ack_b, ack_c, ack_d); end
        total++; if (fc_a !== 16'd0 || fc_d !== 16'd0 || ec_a !== 8'd0 || ec_d !== 8'd0) begin
            bad++; $display("FAIL reset_counts got fc=%0d ec=%0d want 0", fc_d, ec_d); end
        total++; if (err_a !== 1'b0 || done_a !== 1'b0 || ld_a !== 8'd0 || ld_c !== 2'd0) begin
            bad++; $display("FAIL reset_flags got err=%b done=%b ld=%0d want 0", err_a, done_a, ld_a); end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_limit();
        req_a = 1'b1; data_a = 8'd0;
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd1 || ack_a !== 1'b1) begin
            bad++; $display("FAIL limit_first got fc=%0d ack=%b want fc=1 ack=1", fc_a, ack_a); end
        data_a = 8'd1;
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd2 || done_a !== 1'b1 || ack_a !== 1'b0 || err_a !== 1'b0) begin
            bad++; $display("FAIL limit_done got fc=%0d done=%b ack=%b err=%b want 2 1 0 0",
                            fc_a, done_a, ack_a, err_a); end
        data_a = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        total++; if (fc_a !== 16'd2 || ld_a !== 8'd1 || done_a !== 1'b1 || ack_a !== 1'b0) begin
            bad++; $display("FAIL limit_frozen got fc=%0d ld=%0d done=%b want 2 1 1", fc_a, ld_a, done_a); end
        req_a = 1'b0;
    endtask

    task automatic test_backpressure();
        int exp_ack[11];
        int exp_cnt[11];
`ifdef SINK_BACKPRESSURE_EN
        exp_ack = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0};
        exp_cnt = '{1, 2, 3, 3, 4, 5, 6, 6, 7, 8, 8};
`else
        exp_ack = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        exp_cnt = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8};
`endif
        do_reset();
        req_b = 1'b1; data_b = 8'd0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            total++; if (ack_b !== exp_ack[i][0] || fc_b !== exp_cnt[i][15:0]) begin
                bad++; $display("FAIL bp_cycle%0d got ack=%b fc=%0d want ack=%0d fc=%0d",
                                i, ack_b, fc_b, exp_ack[i], exp_cnt[i]); end
            data_b = exp_cnt[i][7:0];
        end
        total++; if (done_b !== 1'b1 || err_b !== 1'b0 || ld_b !== 8'd7) begin
            bad++; $display("FAIL bp_end got done=%b err=%b ld=%0d want 1 0 7", done_b, err_b, ld_b); end
        req_b = 1'b0;
    endtask

    task automatic test_seq_error();
        do_reset();
        req_d = 1'b1; data_d = 8'd0;
        @(posedge clk); #1;
        data_d = 8'd1;
        @(posedge clk); #1;
        total++; if (err_d !== 1'b0 || ec_d !== 8'd0) begin
            bad++; $display("FAIL seq_clean got err=%b ec=%0d want 0 0", err_d, ec_d); end
        data_d = 8'd5;
        @(posedge clk); #1;
        total++; if (err_d !== 1'b1 || ec_d !== 8'd1) begin
            bad++; $display("FAIL seq_err got err=%b ec=%0d want 1 1", err_d, ec_d); end
        data_d = 8'd3;
        @(posedge clk); #1;
        total++; if (ec_d !== 8'd1 || ld_d !== 8'd3 || fc_d !== 16'd4 || err_d !== 1'b1) begin
            bad++; $display("FAIL seq_after got ec=%0d ld=%0d fc=%0d err=%b want 1 3 4 1",
                            ec_d, ld_d, fc_d, err_d); end
        req_d = 1'b0;
    endtask

    task automatic test_wrap();
        logic [1:0] tbl[6];
        int sent = 0;
        int cyc = 0;
        logic will;
        tbl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        req_c = 1'b1; data_c = tbl[0];
        while (sent < 6 && cyc < 30) begin
            will = ack_c;
            @(posedge clk); #1;
            cyc++;
            if (will) begin
                sent++;
                if (sent < 6) data_c = tbl[sent];
            end
        end
        req_c = 1'b0;
        total++; if (sent != 6) begin
            bad++; $display("FAIL wrap_timeout got sent=%0d want 6", sent); end
        total++; if (ec_c !== 8'd0 || err_c !== 1'b0 || fc_c !== 16'd6 || done_c !== 1'b1 || ld_c !== 2'd1) begin
            bad++; $display("FAIL wrap_end got ec=%0d err=%b fc=%0d done=%b ld=%0d want 0 0 6 1 1",
                            ec_c, err_c, fc_c, done_c, ld_c); end
    endtask

    task automatic test_saturate();
        int sent = 0;
        int cyc = 0;
        logic will;
        do_reset();
        req_d = 1'b1; data_d = 8'd1;
        while (sent < 300 && cyc < 1000) begin
            will = ack_d;
            @(posedge clk); #1;
            cyc++;
            if (will) begin
                sent++;
                data_d = 8'(sent + 1);
            end
        end
        req_d = 1'b0;
        total++; if (sent != 300) begin
            bad++; $display("FAIL sat_timeout got sent=%0d want 300", sent); end
        total++; if (ec_d !== 8'd255 || fc_d !== 16'd300 || err_d !== 1'b1) begin
            bad++; $display("FAIL sat_counts got ec=%0d fc=%0d err=%b want 255 300 1", ec_d, fc_d, err_d); end
        total++; if (ld_d !== 8'd44 || done_d !== 1'b0) begin
            bad++; $display("FAIL sat_last got ld=%0d done=%b want 44 0", ld_d, done_d); end
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        int cyc = 0;
        logic will;
        do_reset();
        req_d = 1'b1; data_d = 8'd0;
        while (sent < 5 && cyc < 20) begin
            will = ack_d;
            @(posedge clk); #1;
            cyc++;
            if (will) begin
                sent++;
                data_d = 8'(sent);
            end
        end
        total++; if (fc_d !== 16'd5) begin
            bad++; $display("FAIL rmid_pre got fc=%0d want 5", fc_d); end
        #2 reset = 1'b0;
        #1;
        total++; if (fc_d !== 16'd0 || ec_d !== 8'd0 || err_d !== 1'b0 || ld_d !== 8'd0
                     || ack_d !== 1'b1 || done_d !== 1'b0) begin
            bad++; $display("FAIL rmid_async got fc=%0d ec=%0d err=%b ld=%0d ack=%b done=%b want 0 0 0 0 1 0",
                            fc_d, ec_d, err_d, ld_d, ack_d, done_d); end
        @(negedge clk);
        reset = 1'b1; data_d = 8'd0;
        @(posedge clk); #1;
        total++; if (fc_d !== 16'd1 || err_d !== 1'b0 || ld_d !== 8'd0) begin
            bad++; $display("FAIL rmid_restart got fc=%0d err=%b ld=%0d want 1 0 0", fc_d, err_d, ld_d); end
        data_d = 8'd1;
        @(posedge clk); #1;
        total++; if (fc_d !== 16'd2 || err_d !== 1'b0 || ec_d !== 8'd0) begin
            bad++; $display("FAIL rmid_second got fc=%0d err=%b ec=%0d want 2 0 0", fc_d, err_d, ec_d); end
        req_d = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_limit();
        test_backpressure();
        test_seq_error();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_sink_monitor.md
FLIT_SINK_MONITOR -- requirements
Module: flit_sink_monitor

Interface
REQ-001 Parameter ID, default 0: sink identifier, reported only in the simulation error message.
REQ-002 Parameter DATA_W, default `SIZE: flit width in bits.
REQ-003 Parameter MAX_FLITS, default 16: number of accepted flits after which the sink is done; legal range 1..65535.
REQ-004 Parameter STALL_PERIOD, default 3: accepted flits between forced stall cycles; legal range 1..255.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  upstream flit valid (router tx channel).
REQ-008 data  input  DATA_W  upstream flit payload.
REQ-009 ack  output  1  registered ready to upstream.
REQ-010 flit_count  output  16  number of flits accepted.
REQ-011 err_count  output  8  number of sequence mismatches, saturating.
REQ-012 err  output  1  sticky mismatch flag.
REQ-013 done  output  1  MAX_FLITS flits accepted.
REQ-014 last_data  output  DATA_W  payload of the most recent accepted flit.

Function
REQ-015 A transfer SHALL occur on a rising clk edge where req=1 and ack=1; no other edge transfers a flit.
REQ-016 ack SHALL be a flop output; it is never combinationally dependent on req or data.
REQ-017 The FSM SHALL have states READY (ack=1), STALL (ack=0) and DONE (ack=0).
REQ-018 READY->DONE SHALL occur on the transfer that makes flit_count equal MAX_FLITS; this takes priority over READY->STALL.
REQ-019 READY->STALL SHALL occur on a transfer that brings the stall counter to STALL_PERIOD; the stall counter then clears.
REQ-020 STALL->READY SHALL occur unconditionally after exactly one cycle.
REQ-021 DONE SHALL persist until reset, with ack=0 and all counters frozen.
REQ-022 The expected value SHALL start at 0 and increment by 1 modulo 2^DATA_W on every transfer, whether or not the transfer matched.
REQ-023 On a transfer with data != expected: err SHALL set the next cycle, and err_count SHALL increment, saturating at 255.
REQ-024 flit_count SHALL increment by 1 per transfer; last_data SHALL load data on each transfer.
REQ-025 done SHALL equal (state==DONE).
REQ-026 Latency: ack SHALL drop on the edge after the terminating or stall-triggering transfer, so exactly one flit is accepted on that edge.
REQ-027 req=1 while ack=0 SHALL have no effect; upstream holds the flit.

Reset
REQ-028 When reset=0, asynchronously: state=READY, ack=1, flit_count=0, err_count=0, err=0, last_data=0, expected=0, stall counter=0.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight flit; after release, counting restarts at expected=0.

Configuration
REQ-030 Macro SINK_BACKPRESSURE_EN SHALL compile in the STALL state and stall counter.
REQ-031 With SINK_BACKPRESSURE_EN undefined: STALL is absent, STALL_PERIOD is ignored, and ack=1 in every cycle until DONE.
REQ-032 Error reporting is always present: each mismatch SHALL also $display ID, expected value and received value (simulation only).

Verification
REQ-033 Macro undefined, MAX_FLITS=2, req held 1, data 0 then 1 -> two transfers on consecutive edges; flit_count=2; done=1; ack=0; err=0.
REQ-034 Macro defined, STALL_PERIOD=3, MAX_FLITS=8, continuous correct data -> ack low exactly one cycle after flits 3 and 6; done after flit 8.
REQ-035 Data sequence 0,1,5,3 -> err sets after the third transfer; err_count=1; fourth flit (3) matches; last_data=3.
REQ-036 DATA_W=2, MAX_FLITS=6, data 0,1,2,3,0,1 -> wrap accepted; err_count=0.
REQ-037 300 consecutive mismatches, MAX_FLITS=400 -> err_count saturates at 255; flit_count=300.
REQ-038 reset pulsed low mid-stream after 5 flits -> all outputs at reset values immediately; next data 0 is accepted without error.
